if_pc_ctrl: RTL and testbench
=============================

# if_pc_ctrl

Program-counter controller for the IF stage of the MIPS pipeline. Holds the fetch PC and produces PC+4. Supplies PC+4[31:28] to the jump-address shifter and consumes that shifter's 32-bit jump target. Selects the next PC from the sequential, branch, jump and jump-register sources, honours hazard-unit stalls through a one-entry pending-redirect buffer, and drives the instruction-memory word address and the IF/ID flush.

## Interface

Parameters:
- `PC_W`, 32: PC width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IMEM_ADDR_W`, 8: instruction-memory word-address width.

Ports:
- `i_clk`, in, 1: single clock. All state changes on the rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_stall`, in, 1: hazard-unit stall. Hold the PC.
- `i_branch_taken`, in, 1: taken branch resolved in ID.
- `i_branch_target`, in, PC_W: branch target.
- `i_jump`, in, 1: J/JAL decoded in ID.
- `i_jump_dir`, in, PC_W: jump target from the jump-address shifter.
- `i_jump_reg`, in, 1: JR/JALR decoded in ID.
- `i_jump_reg_target`, in, PC_W: register target.
- `i_halt`, in, 1: halt decoded in ID. Present only with `IF_HALT_EN`.
- `o_pc`, out, PC_W: current fetch PC (registered).
- `o_pc_plus_4`, out, PC_W: `o_pc + 4`, modulo 2^PC_W.
- `o_pc_hi`, out, 4: `o_pc_plus_4[31:28]`, fed to the jump-address shifter.
- `o_imem_addr`, out, IMEM_ADDR_W: `o_pc[IMEM_ADDR_W+1:2]`.
- `o_valid`, out, 1: the fetch in this cycle is valid (registered).
- `o_flush_ifid`, out, 1: squash the instruction entering IF/ID this cycle.
- `o_misaligned`, out, 1: sticky flag, set when a redirect target has non-zero bits [1:0].
- `o_halted`, out, 1: fetch is halted.

## Operation

- Redirect selection priority: jump_reg > branch_taken > jump. The selected target has bits [1:0] forced to 00. If the raw target had non-zero bits [1:0], `o_misaligned` is set at the next edge.
- States:
  - S_RUN: normal fetch.
  - S_HOLD: stalled, no pending redirect.
  - S_PEND: stalled, pending redirect held.
  - S_HALT: only with `IF_HALT_EN`.
- S_RUN transitions:
  - No stall, redirect present: PC ← target, `o_flush_ifid`=1.
  - No stall, no redirect: PC ← PC+4.
  - Stall, redirect present: capture target into the pending buffer, PC held, go to S_PEND.
  - Stall, no redirect: PC held, go to S_HOLD.
- S_HOLD transitions:
  - Stall remains: PC held.
  - Redirect arrives while stalled: capture it, go to S_PEND.
  - Stall drops: behave as S_RUN in that cycle.
- S_PEND:
  - While stalled: a new redirect overwrites the buffer.
  - When the stall drops: PC ← buffered target (a live redirect in that cycle takes precedence over the buffer), `o_flush_ifid`=1, buffer cleared, go to S_RUN.
- Wrap-around: PC+4 at 32'hFFFF_FFFC gives 32'h0000_0000. No flag is raised.
- `o_flush_ifid` is combinational and asserts only in the cycle a redirect is actually applied to the PC, never while stalled.

## Timing

- Reset (synchronous, takes effect at the edge where `i_reset`=1):
  - `o_pc`=RESET_PC, `o_pc_plus_4`=RESET_PC+4.
  - `o_valid`=0, `o_flush_ifid`=0, `o_misaligned`=0, `o_halted`=0.
  - Pending buffer cleared, state S_RUN.
- `o_valid` becomes 1 at the first edge after reset deasserts.
- Reset asserted mid-stall or mid-pending discards all state.
- Redirect latency: redirect in cycle N (not stalled) gives `o_pc`=target in cycle N+1.
- Redirect during a stall ending in cycle M gives `o_pc`=target in cycle M+1.
- `o_pc_plus_4`, `o_pc_hi` and `o_imem_addr` are combinational from the PC register. There is no extra cycle.

## Configuration

- `IF_HALT_EN`, defined:
  - Adds `i_halt` and S_HALT.
  - `i_halt`=1 with no stall moves to S_HALT at the next edge. Halt outranks any redirect in that cycle.
  - In S_HALT: PC frozen, `o_valid`=0, `o_halted`=1, pending buffer discarded. Only reset exits S_HALT.
- `IF_HALT_EN`, undefined: no `i_halt` port, `o_halted` tied to 0, S_HALT does not exist.

## Structure

- Package `mips_if_pkg`: state enum (S_RUN, S_HOLD, S_PEND, S_HALT), `PC_W`, the default `RESET_PC`, and the redirect-source encoding (NONE, JUMP, BRANCH, JREG).
- One sub-module, `if_redirect_buf`: one-entry pending-target register with load, overwrite and clear, plus a valid bit.

## Test plan

- Reset then 4 free-running cycles -> `o_pc` = 0x0, 0x4, 0x8, 0xC, 0x10. `o_valid` is 0 in the reset cycle and 1 afterwards. `o_imem_addr` = 0, 1, 2, 3, 4.
- At PC=0x10 assert `i_jump`, `i_jump_dir`=0x0040_0020 -> `o_flush_ifid`=1 in the same cycle, `o_pc`=0x0040_0020 in the next cycle. `o_pc_hi` follows PC+4[31:28].
- Stall 3 cycles with `i_branch_taken`, target 0x100, asserted in the first stall cycle only -> PC held for 3 cycles. The cycle after the stall drops gives `o_pc`=0x100, with one flush pulse, issued in the release cycle.
- Same cycle: `i_jump_reg` (target 0x200), `i_branch_taken` (target 0x300) and `i_jump` (target 0x400) -> `o_pc`=0x200. With `i_jump_reg_target`=0x203 instead -> `o_pc`=0x200 and `o_misaligned`=1 sticky.
- PC forced to 0xFFFF_FFFC by a jump, then one sequential cycle -> `o_pc`=0x0.
- With `IF_HALT_EN`: `i_halt` at PC=0x20 together with `i_jump` -> S_HALT, `o_pc` stays 0x20, `o_valid`=0, `o_halted`=1. Asserting `i_reset` then gives `o_pc`=RESET_PC.

Source files
------------

// File: rtl/mips_if_pkg.sv
// Shared types and constants for the IF-stage PC controller.
// The S_HALT state exists only when IF_HALT_EN is defined.
package mips_if_pkg;

  localparam int          PC_W     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HOLD = 2'd1,
    S_PEND = 2'd2
`ifdef IF_HALT_EN
    ,
    S_HALT = 2'd3
`endif
  } if_state_e;

  typedef enum logic [1:0] {
    RD_NONE   = 2'd0,
    RD_JUMP   = 2'd1,
    RD_BRANCH = 2'd2,
    RD_JREG   = 2'd3
  } redir_src_e;

endpackage

// File: rtl/if_redirect_buf.sv
// One-entry pending redirect target with a valid bit.
// A load while the entry is valid overwrites it; load wins over clear.
module if_redirect_buf #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_target,
  output logic         o_valid,
  output logic [W-1:0] o_target
);

  logic         valid_q, valid_d;
  logic [W-1:0] target_q, target_d;

  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (i_load) begin
      valid_d  = 1'b1;
      target_d = i_target;
    end else if (i_clear) begin
      valid_d  = 1'b0;
      target_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      target_q <= target_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_target = target_q;

endmodule

// File: rtl/if_pc_ctrl.sv
// IF-stage program-counter controller: next-PC selection, stall handling with a
// pending-redirect buffer, IF/ID flush. Optional halt support: define IF_HALT_EN.
module if_pc_ctrl #(
  parameter int              PC_W        = mips_if_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC    = mips_if_pkg::RESET_PC,
  parameter int              IMEM_ADDR_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_stall,
  input  logic                   i_branch_taken,
  input  logic [PC_W-1:0]        i_branch_target,
  input  logic                   i_jump,
  input  logic [PC_W-1:0]        i_jump_dir,
  input  logic                   i_jump_reg,
  input  logic [PC_W-1:0]        i_jump_reg_target,
`ifdef IF_HALT_EN
  input  logic                   i_halt,
`endif
  output logic [PC_W-1:0]        o_pc,
  output logic [PC_W-1:0]        o_pc_plus_4,
  output logic [3:0]             o_pc_hi,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic                   o_valid,
  output logic                   o_flush_ifid,
  output logic                   o_misaligned,
  output logic                   o_halted
);

  import mips_if_pkg::*;

  if_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;

  redir_src_e      src;
  logic [PC_W-1:0] raw_target;
  logic [PC_W-1:0] live_target;
  logic            live_redir;
  logic            halt_req;
  logic            flush;
  logic            buf_load, buf_clear, buf_valid;
  logic [PC_W-1:0] buf_target;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PC_W'(4);

`ifdef IF_HALT_EN
  assign halt_req = i_halt;
`else
  assign halt_req = 1'b0;
`endif

  always_comb begin
    src = RD_NONE;
    if (i_jump_reg)          src = RD_JREG;
    else if (i_branch_taken) src = RD_BRANCH;
    else if (i_jump)         src = RD_JUMP;
  end

  always_comb begin
    raw_target = '0;
    case (src)
      RD_JREG:   raw_target = i_jump_reg_target;
      RD_BRANCH: raw_target = i_branch_target;
      RD_JUMP:   raw_target = i_jump_dir;
      default:   raw_target = '0;
    endcase
  end

  assign live_redir  = (src != RD_NONE);
  assign live_target = {raw_target[PC_W-1:2], 2'b00};

  if_redirect_buf #(.W(PC_W)) u_redirect_buf (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (buf_load),
    .i_clear  (buf_clear),
    .i_target (live_target),
    .o_valid  (buf_valid),
    .o_target (buf_target)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = 1'b1;
    mis_d     = mis_q;
    flush     = 1'b0;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state_q)
      S_RUN, S_HOLD, S_PEND: begin
        if (halt_req && !i_stall) begin
`ifdef IF_HALT_EN
          state_d = S_HALT;
`endif
          valid_d   = 1'b0;
          buf_clear = 1'b1;
        end else if (i_stall) begin
          // Stalled: never touch the PC, only remember where to go later.
          if (live_redir) begin
            buf_load = 1'b1;
            state_d  = S_PEND;
            if (raw_target[1:0] != 2'b00) mis_d = 1'b1;
          end else begin
            state_d = (state_q == S_PEND) ? S_PEND : S_HOLD;
          end
        end else begin
          state_d   = S_RUN;
          buf_clear = 1'b1;
          if (live_redir) begin
            pc_d  = live_target;
            flush = 1'b1;
            if (raw_target[1:0] != 2'b00) mis_d = 1'b1;
          end else if (state_q == S_PEND && buf_valid) begin
            pc_d  = buf_target;
            flush = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      default: begin
        // Halted: frozen until reset.
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_pc_plus_4  = pc_inc;
  assign o_pc_hi      = pc_inc[31:28];
  assign o_imem_addr  = pc_q[IMEM_ADDR_W+1:2];
  assign o_valid      = valid_q;
  assign o_flush_ifid = flush & ~i_reset;
  assign o_misaligned = mis_q;
`ifdef IF_HALT_EN
  assign o_halted     = (state_q == S_HALT);
`else
  assign o_halted     = 1'b0;
`endif

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Directed self-checking bench for if_pc_ctrl; halt scenario runs only with IF_HALT_EN.
module tb_if_pc_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_dir;
  logic        jreg;
  logic [31:0] jreg_target;
`ifdef IF_HALT_EN
  logic        halt;
`endif
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic [3:0]  pc_hi;
  logic [7:0]  imem_addr;
  logic        valid;
  logic        flush;
  logic        misaligned;
  logic        halted;

  int n_cmp = 0;
  int n_err = 0;

  if_pc_ctrl #(
    .PC_W        (32),
    .RESET_PC    (32'h0000_0000),
    .IMEM_ADDR_W (8)
  ) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_stall           (stall),
    .i_branch_taken    (br_taken),
    .i_branch_target   (br_target),
    .i_jump            (jump),
    .i_jump_dir        (jump_dir),
    .i_jump_reg        (jreg),
    .i_jump_reg_target (jreg_target),
`ifdef IF_HALT_EN
    .i_halt            (halt),
`endif
    .o_pc              (pc),
    .o_pc_plus_4       (pc_plus_4),
    .o_pc_hi           (pc_hi),
    .o_imem_addr       (imem_addr),
    .o_valid           (valid),
    .o_flush_ifid      (flush),
    .o_misaligned      (misaligned),
    .o_halted          (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall = 0; br_taken = 0; br_target = 0;
    jump = 0; jump_dir = 0; jreg = 0; jreg_target = 0;
`ifdef IF_HALT_EN
    halt = 0;
`endif
  endtask

  initial begin
    clear_in();
    reset = 1;
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus_4, 32'h4);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_mis", {31'b0, misaligned}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);

    reset = 0;
    #1;
    chk("run0_pc", pc, 32'h0);
    chk("run0_valid", {31'b0, valid}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("run%0d_pc", i), pc, 32'(4 * i));
      chk($sformatf("run%0d_imem", i), {24'b0, imem_addr}, 32'(i));
      chk($sformatf("run%0d_valid", i), {31'b0, valid}, 32'h1);
    end

    // Jump at PC=0x10
    jump = 1; jump_dir = 32'h0040_0020;
    #1;
    chk("jmp_flush", {31'b0, flush}, 32'h1);
    chk("jmp_pchi_before", {28'b0, pc_hi}, 32'h0);
    step();
    clear_in();
    #1;
    chk("jmp_pc", pc, 32'h0040_0020);
    chk("jmp_flush_after", {31'b0, flush}, 32'h0);

    // Stall 3 cycles, branch only in the first
    stall = 1; br_taken = 1; br_target = 32'h100;
    #1;
    chk("stl_flush0", {31'b0, flush}, 32'h0);
    step();
    br_taken = 0;
    chk("stl_pc1", pc, 32'h0040_0020);
    #1;
    chk("stl_flush1", {31'b0, flush}, 32'h0);
    step();
    chk("stl_pc2", pc, 32'h0040_0020);
    step();
    chk("stl_pc3", pc, 32'h0040_0020);
    stall = 0;
    #1;
    chk("stl_rel_flush", {31'b0, flush}, 32'h1);
    step();
    chk("stl_rel_pc", pc, 32'h100);
    chk("stl_post_flush", {31'b0, flush}, 32'h0);
    step();
    chk("stl_seq_pc", pc, 32'h104);

    // Priority jr > branch > jump
    jreg = 1; jreg_target = 32'h200;
    br_taken = 1; br_target = 32'h300;
    jump = 1; jump_dir = 32'h400;
    step();
    chk("pri_pc", pc, 32'h200);
    chk("pri_mis", {31'b0, misaligned}, 32'h0);
    jreg_target = 32'h203;
    step();
    clear_in();
    chk("mis_pc", pc, 32'h200);
    chk("mis_flag", {31'b0, misaligned}, 32'h1);
    step();
    chk("mis_seq_pc", pc, 32'h204);
    chk("mis_sticky", {31'b0, misaligned}, 32'h1);

    // Wrap-around
    jump = 1; jump_dir = 32'hFFFF_FFFC;
    step();
    clear_in();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus_4, 32'h0);
    step();
    chk("wrap_next_pc", pc, 32'h0);
    chk("wrap_imem", {24'b0, imem_addr}, 32'h0);

    // pc_hi follows PC+4[31:28]
    jump = 1; jump_dir = 32'h7FFF_FFFC;
    step();
    clear_in();
    chk("pchi_val", {28'b0, pc_hi}, 32'h8);

    // Live redirect in the release cycle beats the buffered one
    stall = 1; br_taken = 1; br_target = 32'h500;
    step();
    clear_in();
    jump = 1; jump_dir = 32'h600;
    #1;
    chk("pend_live_flush", {31'b0, flush}, 32'h1);
    step();
    clear_in();
    chk("pend_live_pc", pc, 32'h600);
    step();
    chk("pend_cleared_pc", pc, 32'h604);

    // Stall then redirect arrives later (HOLD -> PEND), overwritten while pending
    stall = 1;
    step();
    jump = 1; jump_dir = 32'h800;
    step();
    jump = 0; br_taken = 1; br_target = 32'h900;
    step();
    clear_in();
    chk("ovw_hold_pc", pc, 32'h604);
    step();
    chk("ovw_pc", pc, 32'h900);

    // Reset while pending discards buffered target
    stall = 1; jump = 1; jump_dir = 32'h700;
    step();
    clear_in();
    stall = 1; reset = 1;
    step();
    chk("rstpend_pc", pc, 32'h0);
    chk("rstpend_valid", {31'b0, valid}, 32'h0);
    reset = 0; stall = 0;
    #1;
    chk("rstpend_flush", {31'b0, flush}, 32'h0);
    step();
    chk("rstpend_next_pc", pc, 32'h4);

`ifdef IF_HALT_EN
    jump = 1; jump_dir = 32'h20;
    step();
    clear_in();
    halt = 1; jump = 1; jump_dir = 32'h980;
    #1;
    chk("halt_flush", {31'b0, flush}, 32'h0);
    step();
    clear_in();
    chk("halt_pc", pc, 32'h20);
    chk("halt_valid", {31'b0, valid}, 32'h0);
    chk("halt_halted", {31'b0, halted}, 32'h1);
    step();
    chk("halt_hold_pc", pc, 32'h20);
    reset = 1;
    step();
    reset = 0;
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_halted", {31'b0, halted}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
